instr_fetch_unit: RTL

INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

---
 rtl/riscv_pkg.sv | 19 +
 rtl/instr_fetch_fifo.sv | 69 ++++++
 rtl/instr_fetch_unit.sv | 134 +++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared RISC-V constants for the fetch path: instruction width, canonical NOP
// and the major opcodes used by images loaded into the instruction ROM.
package riscv_pkg;

    localparam int          INSTR_W = 32;
    localparam logic [31:0] NOP     = 32'h0000_0013;

    localparam logic [6:0] I_IMM  = 7'b0010011;
    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] S_TYPE = 7'b0100011;
    localparam logic [6:0] R_TYPE = 7'b0110011;
    localparam logic [6:0] B_TYPE = 7'b1100011;

    function automatic logic [6:0] opcode_of(input logic [INSTR_W-1:0] instr);
        return instr[6:0];
    endfunction

endpackage

// File: rtl/instr_fetch_fifo.sv
// Power-of-two bundle queue with flush, push and pop; the head entry is always
// visible on head_data, and flush wins over any push or pop in the same cycle.
module instr_fetch_fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   push,
    input  logic [W-1:0]           push_data,
    input  logic                   pop,
    output logic [W-1:0]           head_data,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PW = $clog2(DEPTH);

    logic [W-1:0]  mem_r [DEPTH];
    logic [PW-1:0] wr_ptr_r;
    logic [PW-1:0] rd_ptr_r;
    logic [PW:0]   count_r;
    logic          do_push_s;
    logic          do_pop_s;

    // Qualify requests against the current fill level.
    always_comb begin
        do_push_s = push && (count_r < (PW+1)'(DEPTH));
        do_pop_s  = pop && (count_r != {(PW+1){1'b0}});
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            count_r  <= {(PW+1){1'b0}};
        end else if (flush) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            count_r  <= {(PW+1){1'b0}};
        end else begin
            if (do_push_s) wr_ptr_r <= wr_ptr_r + {{(PW-1){1'b0}}, 1'b1};
            else           wr_ptr_r <= wr_ptr_r;
            if (do_pop_s)  rd_ptr_r <= rd_ptr_r + {{(PW-1){1'b0}}, 1'b1};
            else           rd_ptr_r <= rd_ptr_r;
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + {{PW{1'b0}}, 1'b1};
                2'b01:   count_r <= count_r - {{PW{1'b0}}, 1'b1};
                default: count_r <= count_r;
            endcase
        end
    end

    // Entry storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_r[i] <= {W{1'b0}};
        end else if (do_push_s && !flush) begin
            mem_r[wr_ptr_r] <= push_data;
        end else begin
            mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
        end
    end

    assign head_data = mem_r[rd_ptr_r];
    assign count     = count_r;

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: PC register, synchronous-read ROM producing ISSUE_W-wide
// bundles, and a credit-gated fetch queue that redirects flush in one cycle.
module instr_fetch_unit
    import riscv_pkg::*;
#(
    parameter int          ISSUE_W   = 2,
    parameter int          DEPTH     = 1024,
    parameter int          QDEPTH    = 4,
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter              INIT_FILE = ""
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       redirect_valid,
    input  logic [31:0]                redirect_pc,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [31:0]                out_pc,
    output logic [INSTR_W*ISSUE_W-1:0] out_instr,
    output logic [ISSUE_W-1:0]         out_slot_valid
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(QDEPTH) + 1;
    localparam int IW = INSTR_W * ISSUE_W;
    localparam int BW = 32 + ISSUE_W + IW;

    logic [INSTR_W-1:0] rom [DEPTH] = '{default: NOP};

    logic [31:0]        pc_r;
    logic               fetch_en_r;
    logic               rd_valid_r;
    logic [31:0]        rd_pc_r;
    logic [IW-1:0]      rd_instr_r;
    logic [ISSUE_W-1:0] rd_sv_r;

    logic [32:0]        word_idx_s;
    logic [ISSUE_W-1:0] slot_ok_s;
    logic [IW-1:0]      rom_word_s;
    logic [CW:0]        credit_s;
    logic [CW-1:0]      q_count_s;
    logic [BW-1:0]      head_s;
    logic               in_rom_s;
    logic               issue_s;
    logic               push_s;
    logic               pop_s;

    // ROM lookup per slot; words past the end of the ROM become invalid NOPs.
    always_comb begin
        word_idx_s = {3'b000, pc_r[31:2]};
        slot_ok_s  = {ISSUE_W{1'b0}};
        rom_word_s = {ISSUE_W{NOP}};
        for (int k = 0; k < ISSUE_W; k++) begin
            if ((word_idx_s + 33'(k)) < 33'(DEPTH)) begin
                slot_ok_s[k]             = 1'b1;
                rom_word_s[32*k +: 32]   = rom[AW'(word_idx_s + 33'(k))];
            end else begin
                slot_ok_s[k]             = 1'b0;
                rom_word_s[32*k +: 32]   = NOP;
            end
        end
    end

    // Credit rule counts the read in flight so a queued bundle is never dropped.
    always_comb begin
        in_rom_s  = word_idx_s < 33'(DEPTH);
        credit_s  = {1'b0, q_count_s} + {{CW{1'b0}}, rd_valid_r};
        issue_s   = fetch_en_r && !redirect_valid && in_rom_s
                    && (credit_s < (CW+1)'(QDEPTH));
        push_s    = rd_valid_r && !redirect_valid;
        out_valid = (q_count_s != {CW{1'b0}});
        pop_s     = out_valid && out_ready && !redirect_valid;
    end

    // Fetch PC; fetch_en delays the first fetch so reset behaves like a redirect.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_r       <= RESET_PC;
            fetch_en_r <= 1'b0;
        end else begin
            fetch_en_r <= 1'b1;
            if (redirect_valid) pc_r <= redirect_pc & 32'hFFFF_FFFC;
            else if (issue_s)   pc_r <= pc_r + 32'(4 * ISSUE_W);
            else                pc_r <= pc_r;
        end
    end

    // Synchronous ROM read stage carrying the pc tag and slot validity.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid_r <= 1'b0;
            rd_pc_r    <= 32'h0000_0000;
            rd_instr_r <= {ISSUE_W{NOP}};
            rd_sv_r    <= {ISSUE_W{1'b0}};
        end else begin
            rd_valid_r <= issue_s;
            if (issue_s) begin
                rd_pc_r    <= pc_r;
                rd_instr_r <= rom_word_s;
                rd_sv_r    <= slot_ok_s;
            end else begin
                rd_pc_r    <= rd_pc_r;
                rd_instr_r <= rd_instr_r;
                rd_sv_r    <= rd_sv_r;
            end
        end
    end

    instr_fetch_fifo #(
        .W     (BW),
        .DEPTH (QDEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (redirect_valid),
        .push      (push_s),
        .push_data ({rd_pc_r, rd_sv_r, rd_instr_r}),
        .pop       (pop_s),
        .head_data (head_s),
        .count     (q_count_s)
    );

    // Idle outputs show the reset pattern rather than stale queue contents.
    always_comb begin
        if (out_valid) begin
            {out_pc, out_slot_valid, out_instr} = head_s;
        end else begin
            out_pc         = 32'h0000_0000;
            out_slot_valid = {ISSUE_W{1'b0}};
            out_instr      = {ISSUE_W{NOP}};
        end
    end

endmodule
